// File: rtl/loader_pkg.sv
// ============================================================================
//  Module   : loader_pkg
//  Brief    : Shared types and constants for the UART instruction loader.
//             The CSUM state only exists when INSTR_LOADER_CHECKSUM_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
`ifdef INSTR_LOADER_CHECKSUM_EN
        ST_CSUM = 3'd3,
`endif
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Truncating division: 25 MHz / 115200 gives 217.
    function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
        return clk_freq_hz / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_byte.sv
// ============================================================================
//  Module   : uart_rx_byte
//  Brief    : 8N1 UART byte receiver with two-flop synchronizer, start-bit
//             glitch rejection and stop-bit framing check.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             rxd_meta_q;
    logic             rxd_sync_q;
    logic             rxd_prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;

    // Synchronizer and edge-history flops reset to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rxd_meta_q <= rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        bit_d   = bit_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (rxd_prev_q && !rxd_sync_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    bit_d = '0;
                    // A line that is already high again was only a glitch.
                    state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxd_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    valid_d = rxd_sync_q;
                    ferr_d  = !rxd_sync_q;
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    assign rx_valid = valid_q;
    assign rx_data  = shift_q;
    assign rx_ferr  = ferr_q;

endmodule

`default_nettype wire

// File: rtl/instr_loader.sv
// ============================================================================
//  Module   : instr_loader
//  Brief    : Receives a framed program image over UART, writes little-endian
//             32-bit words to instruction memory and holds the CPU in reset
//             until a complete image is loaded. Define INSTR_LOADER_CHECKSUM_EN
//             to require a trailing 8-bit additive checksum byte.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_loader
    import loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int BAUD        = 115_200,
    parameter int ADDR_W      = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ftdi_rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    // Word counter must hold both any LEN byte and the full depth 2**ADDR_W.
    localparam int                CNT_W    = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  FULL_LEN = CNT_W'(1) << ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ferr;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rxd      (ftdi_rxd),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    ld_state_e         state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        lane_q, lane_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [23:0]       shift_q, shift_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            lane_q  <= '0;
            waddr_q <= '0;
            shift_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            lane_q  <= lane_d;
            waddr_q <= waddr_d;
            shift_q <= shift_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        lane_d  = lane_q;
        waddr_d = waddr_q;
        shift_d = shift_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (rx_ferr) begin
                    state_d = ST_ERR;
                end else if (rx_valid) begin
                    count_d = (rx_data == 8'd0) ? FULL_LEN
                                                : {{(CNT_W-8){1'b0}}, rx_data};
                    lane_d  = '0;
                    waddr_d = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_ferr) begin
                    state_d = ST_ERR;
                end else if (rx_valid) begin
                    lane_d = lane_q + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
                    csum_d = csum_q + rx_data;
`endif
                    // Bytes enter at the top so byte 0 lands in [7:0] after three shifts.
                    shift_d = {rx_data, shift_q[23:8]};
                    if (lane_q == 2'd3) begin
                        we_d    = 1'b1;
                        addr_d  = waddr_q;
                        wdata_d = {rx_data, shift_q};
                        waddr_d = waddr_q + ADDR_ONE;
                        count_d = count_q - CNT_ONE;
                        if (count_q == CNT_ONE) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_DONE;
`endif
                        end
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_ferr) begin
                    state_d = ST_ERR;
                end else if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_hold  = (state_q != ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign err       = (state_q == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_instr_loader.sv
// ============================================================================
//  Module   : tb_instr_loader
//  Brief    : Scoreboard bench for instr_loader driving serial frames on ftdi_rxd.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_instr_loader;

    localparam int CPB    = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ftdi_rxd = 1'b1;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    instr_loader #(
        .CLK_FREQ_HZ (CPB * 100),
        .BAUD        (100),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ftdi_rxd  (ftdi_rxd),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] words[$];
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0]  tb_sum;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe is matched against the oldest expected write.
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                         mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {{(32-ADDR_W){1'b0}}, mem_addr}, {{(32-ADDR_W){1'b0}}, mon_e.addr});
                check("wr_data", mem_wdata, mon_e.data);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ftdi_rxd = b;
        wait_clks(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        send_bit(1'b1);
        send_bit(1'b1);
    endtask

    // Sends sync, LEN and every word in `words`, queuing the expected writes.
    task automatic send_frame(input logic [7:0] len);
        logic [31:0] wd;
        wr_t         e;
`ifdef INSTR_LOADER_CHECKSUM_EN
        tb_sum = 8'h00;
`endif
        send_byte(8'hA5);
        send_byte(len);
        for (int w = 0; w < words.size(); w++) begin
            wd     = words[w];
            e.addr = ADDR_W'(w);
            e.data = wd;
            exp_q.push_back(e);
            for (int k = 0; k < 4; k++) begin
                send_byte(wd[8*k +: 8]);
`ifdef INSTR_LOADER_CHECKSUM_EN
                tb_sum = tb_sum + wd[8*k +: 8];
`endif
            end
        end
    endtask

    task automatic check_status(input string tag, input logic exp_done, input logic exp_err);
        check({tag, "_done"}, {31'b0, done}, {31'b0, exp_done});
        check({tag, "_err"}, {31'b0, err}, {31'b0, exp_err});
        check({tag, "_hold"}, {31'b0, cpu_hold}, {31'b0, !exp_done});
        check({tag, "_pending"}, exp_q.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        check({tag, "_addr"}, {{(32-ADDR_W){1'b0}}, mem_addr}, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_hold"}, {31'b0, cpu_hold}, 32'd1);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_err"}, {31'b0, err}, 32'd0);
    endtask

    initial begin
        wait_clks(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clks(4 * CPB);

        // Junk before sync is ignored while idle.
        send_byte(8'h11);
        send_byte(8'h22);
        check_status("junk_idle", 1'b0, 1'b0);
        words = '{32'h0010_0073};
        send_frame(8'h01);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(tb_sum);
`endif
        check_status("junk_frame", 1'b1, 1'b0);

        // Two-word program, restarted from DONE.
        words = '{32'h0000_0033, 32'h0010_8093};
        send_frame(8'h02);
`ifdef INSTR_LOADER_CHECKSUM_EN
        check("csum_model", {24'b0, tb_sum}, 32'h56);
        send_byte(tb_sum);
`endif
        check_status("two_word", 1'b1, 1'b0);
        check("addr_hold", {{(32-ADDR_W){1'b0}}, mem_addr}, 32'd1);
        check("wdata_hold", mem_wdata, 32'h0010_8093);

`ifdef INSTR_LOADER_CHECKSUM_EN
        // Bad checksum: words still land, load is flagged as failed.
        send_frame(8'h02);
        send_byte(tb_sum ^ 8'h01);
        check_status("bad_csum", 1'b0, 1'b1);
`endif

        // Framing error in the middle of DATA, then recovery.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h73);
        send_byte(8'h00, 1'b0);
        check_status("ferr", 1'b0, 1'b1);
        words = '{32'h0010_0073};
        send_frame(8'h01);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(tb_sum);
`endif
        check_status("ferr_recover", 1'b1, 1'b0);

        // LEN=0 loads the full depth, each address exactly once.
        words.delete();
        for (int i = 0; i < DEPTH; i++) words.push_back((32'(i) * 32'h0101_0101) ^ 32'hA5C3_0F00);
        send_frame(8'h00);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(tb_sum);
`endif
        check_status("full_depth", 1'b1, 1'b0);
        check("full_last_addr", {{(32-ADDR_W){1'b0}}, mem_addr}, 32'(DEPTH - 1));

        // Reset during the third data byte aborts the load.
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h11);
        ftdi_rxd = 1'b0;
        wait_clks(3 * CPB);
        rst = 1'b1;
        wait_clks(2);
        check_reset_outputs("mid_reset");
        ftdi_rxd = 1'b1;
        wait_clks(4 * CPB);
        rst = 1'b0;
        wait_clks(4 * CPB);
        words = '{32'hDEAD_BEEF, 32'h0000_0013};
        send_frame(8'h02);
`ifdef INSTR_LOADER_CHECKSUM_EN
        send_byte(tb_sum);
`endif
        check_status("post_reset", 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
